// File: rtl/gate_ref_select.sv
// gate_ref_select: golden-reference 3-input gate evaluator for the IC tester.
// The selected gate function (AND/OR/NAND/NOR/XOR/XNOR) is evaluated on
// the current stimulus bits and registered with exactly one cycle of latency.
// Optional feature macro: GATE_REF_TABLE_EN adds a registered 8-row
// expected truth table on truth_table (bit i = f(A=i[0], B=i[1], C=i[2])).
module gate_ref_select #(
    parameter logic INVALID_Y = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic [2:0] gateSelect,
    output logic       Y,
    output logic       sel_err
`ifdef GATE_REF_TABLE_EN
    ,
    output logic [7:0] truth_table
`endif
);

    // Select codes; 110 and 111 are unused.
    localparam logic [2:0] SEL_AND  = 3'b000;
    localparam logic [2:0] SEL_OR   = 3'b001;
    localparam logic [2:0] SEL_NAND = 3'b010;
    localparam logic [2:0] SEL_NOR  = 3'b011;
    localparam logic [2:0] SEL_XOR  = 3'b100;
    localparam logic [2:0] SEL_XNOR = 3'b101;

    // Evaluates the selected gate on one stimulus pattern {C,B,A}.
    // Unused select codes yield INVALID_Y so Y and the table agree.
    function automatic logic gate_eval(input logic [2:0] sel, input logic [2:0] abc);
        logic all_and;
        logic any_or;
        logic parity;
        all_and = &abc;
        any_or  = |abc;
        parity  = ^abc;
        case (sel)
            SEL_AND:  gate_eval = all_and;
            SEL_OR:   gate_eval = any_or;
            SEL_NAND: gate_eval = ~all_and;
            SEL_NOR:  gate_eval = ~any_or;
            SEL_XOR:  gate_eval = parity;
            SEL_XNOR: gate_eval = ~parity;
            default:  gate_eval = INVALID_Y;
        endcase
    endfunction

    logic y_reg;
    logic y_next;
    logic sel_err_reg;
    logic sel_err_next;

    // Combinational gate function on the live stimulus and select.
    always_comb begin
        y_next       = gate_eval(gateSelect, {C, B, A});
        sel_err_next = gateSelect[2] & gateSelect[1];
    end

    // Output registers; reset has priority over everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            y_reg       <= 1'b0;
            sel_err_reg <= 1'b0;
        end else begin
            y_reg       <= y_next;
            sel_err_reg <= sel_err_next;
        end
    end

    assign Y       = y_reg;
    assign sel_err = sel_err_reg;

`ifdef GATE_REF_TABLE_EN
    logic [7:0] tt_reg;
    logic [7:0] tt_next;

    // One evaluator per truth-table row; row index gi is the pattern {C,B,A}.
    for (genvar gi = 0; gi < 8; gi++) begin : g_tt
        assign tt_next[gi] = gate_eval(gateSelect, 3'(gi));
    end

    // Truth-table register, cleared by reset like Y.
    always_ff @(posedge clk) begin
        if (reset) begin
            tt_reg <= 8'h00;
        end else begin
            tt_reg <= tt_next;
        end
    end

    assign truth_table = tt_reg;
`endif

endmodule

// File: tb/tb_gate_ref_select.sv
// Testbench for gate_ref_select: table-driven vectors through a scoreboard
// queue, plus a hand-written reset-during-sweep sequence.
// Truth-table checks are active when GATE_REF_TABLE_EN is defined.
module tb_gate_ref_select;

    localparam logic INVALID_Y = 1'b0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       A = 1'b0;
    logic       B = 1'b0;
    logic       C = 1'b0;
    logic [2:0] gateSelect = 3'b000;
    logic       Y;
    logic       sel_err;
`ifdef GATE_REF_TABLE_EN
    logic [7:0] truth_table;
`endif

    gate_ref_select #(.INVALID_Y(INVALID_Y)) dut (
        .clk        (clk),
        .reset      (reset),
        .A          (A),
        .B          (B),
        .C          (C),
        .gateSelect (gateSelect),
        .Y          (Y),
        .sel_err    (sel_err)
`ifdef GATE_REF_TABLE_EN
        ,
        .truth_table(truth_table)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [2:0] sel;
        logic [2:0] abc;
        logic       y;
        logic       err;
        logic [7:0] tt;
    } vec_t;

    typedef struct {
        logic       y;
        logic       err;
        logic [7:0] tt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    // Reference truth tables written out by hand from the gate definitions.
    function automatic logic [7:0] ref_table(input logic [2:0] sel);
        case (sel)
            3'b000:  ref_table = 8'h80;
            3'b001:  ref_table = 8'hFE;
            3'b010:  ref_table = 8'h7F;
            3'b011:  ref_table = 8'h01;
            3'b100:  ref_table = 8'h96;
            3'b101:  ref_table = 8'h69;
            default: ref_table = {8{INVALID_Y}};
        endcase
    endfunction

    function automatic vec_t mk(input logic rst, input logic [2:0] sel, input logic [2:0] abc);
        vec_t v;
        logic [7:0] t;
        t     = ref_table(sel);
        v.rst = rst;
        v.sel = sel;
        v.abc = abc;
        if (rst) begin
            v.y   = 1'b0;
            v.err = 1'b0;
            v.tt  = 8'h00;
        end else begin
            v.y   = t[abc];
            v.err = (sel == 3'b110) || (sel == 3'b111);
            v.tt  = t;
        end
        return v;
    endfunction

    task automatic check_bit(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0b want=%0b", name, got, want);
        end
    endtask

    // Drive one vector on the falling edge, record its expectation, then
    // compare against the DUT just after the following rising edge.
    task automatic step(input vec_t v);
        exp_t e;
        @(negedge clk);
        reset      = v.rst;
        A          = v.abc[0];
        B          = v.abc[1];
        C          = v.abc[2];
        gateSelect = v.sel;
        e.y   = v.y;
        e.err = v.err;
        e.tt  = v.tt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty got=0 want=1");
        end else begin
            e = sb.pop_front();
            $display("txn rst=%0b sel=%03b abc=%03b Y=%0b err=%0b", v.rst, v.sel, v.abc, Y, sel_err);
            check_bit($sformatf("Y sel=%03b abc=%03b rst=%0b", v.sel, v.abc, v.rst), Y, e.y);
            check_bit($sformatf("sel_err sel=%03b abc=%03b rst=%0b", v.sel, v.abc, v.rst), sel_err, e.err);
`ifdef GATE_REF_TABLE_EN
            total++;
            if (truth_table !== e.tt) begin
                bad++;
                $display("FAIL truth_table sel=%03b got=%02h want=%02h", v.sel, truth_table, e.tt);
            end
`endif
        end
    endtask

    initial begin
        logic [2:0] sweep_sels[6];
        sweep_sels = '{3'b000, 3'b010, 3'b001, 3'b011, 3'b100, 3'b101};

        // Reset for two cycles with arbitrary inputs.
        vecs.push_back(mk(1'b1, 3'b100, 3'b111));
        vecs.push_back(mk(1'b1, 3'b001, 3'b101));
        // Full sweeps of every valid select.
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < 8; i++) begin
                vecs.push_back(mk(1'b0, sweep_sels[s], 3'(i)));
            end
        end
        // Unused codes then recovery to AND.
        vecs.push_back(mk(1'b0, 3'b110, 3'b111));
        vecs.push_back(mk(1'b0, 3'b111, 3'b111));
        vecs.push_back(mk(1'b0, 3'b000, 3'b111));
        vecs.push_back(mk(1'b0, 3'b111, 3'b000));
        vecs.push_back(mk(1'b0, 3'b101, 3'b000));

        foreach (vecs[k]) begin
            step(vecs[k]);
        end

        // Reset mid-sweep with NOR: ABC=000 would give 1, reset forces 0,
        // then normal output resumes on the first edge after release.
        step(mk(1'b0, 3'b011, 3'b101));
        step(mk(1'b1, 3'b011, 3'b000));
        step(mk(1'b0, 3'b011, 3'b000));
        step(mk(1'b0, 3'b011, 3'b001));

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
